// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among N_REQ byte producers
// An optional packet lock keeps the grant on one owner until its last byte or a lock timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_BITS    = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                       sysclk_in,
  input  logic                       rst_in,
  input  logic [N_REQ-1:0]           req_valid_in,
  input  logic [N_REQ*DATA_BITS-1:0] req_data_in,
  input  logic [N_REQ-1:0]           req_last_in,
  output logic [N_REQ-1:0]           req_ready_out,
  output logic [DATA_BITS-1:0]       tx_data_out,
  output logic                       data_rdy_out,
  input  logic                       tx_busy_in,
  output logic                       grant_valid_out,
  output logic [$clog2(N_REQ)-1:0]   grant_idx_out
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_HOLD} state_t;

  state_t               r_state, w_state_n;
  logic [N_REQ-1:0]     r_ready, w_ready_n;
  logic [DATA_BITS-1:0] r_tx_data, w_tx_data_n;
  logic                 r_data_rdy, w_data_rdy_n;
  logic                 r_grant_valid, w_grant_valid_n;
  logic [IDX_W-1:0]     r_grant_idx, w_grant_idx_n;
  logic [IDX_W-1:0]     r_last_grant, w_last_grant_n;
  logic                 r_last_q, w_last_q_n;
  logic [CNT_W-1:0]     r_cnt, w_cnt_n;

  logic                 w_found_hi, w_found_any;
  logic [IDX_W-1:0]     w_sel_hi, w_sel_any, w_sel;
  logic [DATA_BITS-1:0] w_sel_data, w_own_data;
  logic                 w_sel_last, w_own_last, w_own_valid;

  // Round-robin pick: lowest valid index above the last grant, else lowest valid overall.
  always_comb begin
    w_found_hi  = 1'b0;
    w_found_any = 1'b0;
    w_sel_hi    = '0;
    w_sel_any   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_in[i]) begin
        w_found_any = 1'b1;
        w_sel_any   = IDX_W'(i);
        if (IDX_W'(i) > r_last_grant) begin
          w_found_hi = 1'b1;
          w_sel_hi   = IDX_W'(i);
        end
      end
    end
    w_sel = w_found_hi ? w_sel_hi : w_sel_any;
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    w_own_data = '0;
    w_own_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == w_sel) begin
        w_sel_data = req_data_in[i*DATA_BITS +: DATA_BITS];
        w_sel_last = req_last_in[i];
      end
      if (IDX_W'(i) == r_grant_idx) begin
        w_own_data = req_data_in[i*DATA_BITS +: DATA_BITS];
        w_own_last = req_last_in[i];
      end
    end
    w_own_valid = req_valid_in[r_grant_idx];
  end

  always_comb begin
    w_state_n       = r_state;
    w_ready_n       = '0;
    w_tx_data_n     = r_tx_data;
    w_data_rdy_n    = r_data_rdy;
    w_grant_valid_n = r_grant_valid;
    w_grant_idx_n   = r_grant_idx;
    w_last_grant_n  = r_last_grant;
    w_last_q_n      = r_last_q;
    w_cnt_n         = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found_any) begin
          w_tx_data_n      = w_sel_data;
          w_last_q_n       = w_sel_last;
          w_grant_idx_n    = w_sel;
          w_last_grant_n   = w_sel;
          w_grant_valid_n  = 1'b1;
          w_ready_n[w_sel] = 1'b1;
          w_data_rdy_n     = 1'b1;
          w_state_n        = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tx_busy_in) begin
          w_data_rdy_n = 1'b0;
          w_state_n    = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy_in) begin
          if (r_last_q) begin
            w_state_n       = S_IDLE;
            w_grant_valid_n = 1'b0;
          end else begin
            w_state_n = S_HOLD;
            w_cnt_n   = '0;
          end
        end
      end
      S_HOLD: begin
        // Other requesters are deliberately ignored while the packet is locked.
        if (w_own_valid) begin
          w_tx_data_n            = w_own_data;
          w_last_q_n             = w_own_last;
          w_ready_n[r_grant_idx] = 1'b1;
          w_data_rdy_n           = 1'b1;
          w_state_n              = S_LOAD;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
          if (LOCK_TIMEOUT != 0 && w_cnt_n == CNT_W'(LOCK_TIMEOUT)) begin
            w_state_n       = S_IDLE;
            w_grant_valid_n = 1'b0;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_ready       <= '0;
      r_tx_data     <= '0;
      r_data_rdy    <= 1'b0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_last_grant  <= IDX_W'(N_REQ - 1);
      r_last_q      <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_n;
      r_ready       <= w_ready_n;
      r_tx_data     <= w_tx_data_n;
      r_data_rdy    <= w_data_rdy_n;
      r_grant_valid <= w_grant_valid_n;
      r_grant_idx   <= w_grant_idx_n;
      r_last_grant  <= w_last_grant_n;
      r_last_q      <= w_last_q_n;
      r_cnt         <= w_cnt_n;
    end
  end

  assign req_ready_out   = r_ready;
  assign tx_data_out     = r_tx_data;
  assign data_rdy_out    = r_data_rdy;
  assign grant_valid_out = r_grant_valid;
  assign grant_idx_out   = r_grant_idx;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Queue-driven requesters, a behavioural uart_tx stand-in and a transaction-level arbitration model.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int LT    = 16;
  localparam int FRAME = 6;
  localparam int IW    = 2;

  logic            sysclk_in = 1'b0;
  logic            rst_in = 1'b0;
  logic [N-1:0]    req_valid_in;
  logic [N*DW-1:0] req_data_in;
  logic [N-1:0]    req_last_in;
  logic [N-1:0]    req_ready_out;
  logic [DW-1:0]   tx_data_out;
  logic            data_rdy_out;
  logic            tx_busy_in;
  logic            grant_valid_out;
  logic [IW-1:0]   grant_idx_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]    rq [N][$];
  logic [N-1:0]  en;
  logic [DW-1:0] sent [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] tx_cur;
  int            tx_cnt;

  uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DW), .LOCK_TIMEOUT(LT)) dut (
    .sysclk_in(sysclk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_last_in(req_last_in),
    .req_ready_out(req_ready_out), .tx_data_out(tx_data_out), .data_rdy_out(data_rdy_out),
    .tx_busy_in(tx_busy_in), .grant_valid_out(grant_valid_out), .grant_idx_out(grant_idx_out)
  );

  always #5 sysclk_in = ~sysclk_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Requesters: present the head of each queue, pop it on the edge that sees ready.
  initial begin
    logic [N-1:0] rdy_s;
    en = '0;
    req_valid_in = '0;
    req_data_in = '0;
    req_last_in = '0;
    forever begin
      @(negedge sysclk_in);
      rdy_s = req_ready_out;
      @(posedge sysclk_in);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst_in && rdy_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid_in[i] = en[i] && (rq[i].size() > 0);
        req_data_in[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0][7:0] : '0;
        req_last_in[i] = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
      end
    end
  end

  // uart_tx stand-in: accepts on data_rdy, stays busy for FRAME cycles.
  initial begin
    tx_busy_in = 1'b0;
    tx_cnt = 0;
    forever begin
      @(posedge sysclk_in);
      #1;
      if (rst_in) begin
        tx_busy_in = 1'b0;
        tx_cnt = 0;
      end else if (tx_busy_in) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_busy_in = 1'b0;
      end else if (data_rdy_out === 1'b1) begin
        sent.push_back(tx_data_out);
        tx_cur = tx_data_out;
        tx_busy_in = 1'b1;
        tx_cnt = FRAME;
      end
    end
  end

  // Model + per-cycle compare.
  initial begin
    int m_last, m_owner, m_idle, idx, expi;
    bit m_pending, m_seen, prev_busy;
    logic [N-1:0] s_valid, s_last;
    logic [N*DW-1:0] s_data;
    m_last = N - 1; m_owner = -1; m_idle = 0; m_pending = 0; m_seen = 0; prev_busy = 0;
    s_valid = '0; s_last = '0; s_data = '0;
    forever begin
      @(negedge sysclk_in);
      if (rst_in) begin
        m_last = N - 1; m_owner = -1; m_idle = 0; m_pending = 0; m_seen = 0; prev_busy = 0;
        s_valid = '0;
      end else begin
        if (req_ready_out != '0) begin
          idx = 0;
          for (int i = N - 1; i >= 0; i--) if (req_ready_out[i]) idx = i;
          expi = (m_owner >= 0) ? m_owner : rr_pick(s_valid, m_last);
          chk("ready_onehot", $countones(req_ready_out), 1);
          chk("grant_order", idx, expi);
          chk("ready_had_valid", s_valid[idx], 1'b1);
          chk("tx_data_on_grant", tx_data_out, s_data[idx*DW +: DW]);
          chk("data_rdy_on_grant", data_rdy_out, 1'b1);
          chk("grant_valid_on_grant", grant_valid_out, 1'b1);
          chk("grant_idx_on_grant", grant_idx_out, idx);
          m_last = idx;
          m_owner = s_last[idx] ? -1 : idx;
          m_pending = 1; m_seen = 0; m_idle = 0;
        end
        if (tx_busy_in) begin
          if (m_pending) m_seen = 1;
          chk("tx_data_stable", tx_data_out, tx_cur);
          if (prev_busy) chk("data_rdy_cleared", data_rdy_out, 1'b0);
        end else if (m_pending && m_seen) begin
          m_pending = 0;
        end
        if (m_pending) chk("grant_valid_busy", grant_valid_out, 1'b1);
        if (m_owner >= 0 && !m_pending && !tx_busy_in && !req_valid_in[m_owner]) begin
          m_idle++;
          if (m_idle == LT + 1) m_owner = -1;
        end
        prev_busy = tx_busy_in;
        s_valid = req_valid_in;
        s_last = req_last_in;
        s_data = req_data_in;
      end
    end
  end

  task automatic do_reset();
    rst_in = 1'b1;
    #1;
    chk("rst_ready", req_ready_out, 0);
    chk("rst_data_rdy", data_rdy_out, 0);
    chk("rst_tx_data", tx_data_out, 0);
    chk("rst_grant_valid", grant_valid_out, 0);
    chk("rst_grant_idx", grant_idx_out, 0);
    for (int i = 0; i < N; i++) rq[i].delete();
    en = '0;
    sent.delete();
    repeat (2) @(posedge sysclk_in);
    #3;
    rst_in = 1'b0;
    @(negedge sysclk_in);
    chk("post_rst_grant_valid", grant_valid_out, 0);
    chk("post_rst_data_rdy", data_rdy_out, 0);
  endtask

  task automatic wait_sent(input int n);
    int t;
    t = 0;
    while ((sent.size() < n || tx_busy_in) && t < 2000) begin
      @(negedge sysclk_in);
      t++;
    end
    chk("wait_sent_in_time", t < 2000, 1);
    repeat (4) @(negedge sysclk_in);
  endtask

  task automatic check_sent();
    chk("sent_count", sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) chk("sent_byte", sent[i], exp_q[i]);
  endtask

  task automatic wait_ready(input int i);
    int t;
    t = 0;
    while (!req_ready_out[i] && t < 500) begin
      @(negedge sysclk_in);
      t++;
    end
    chk("wait_ready_in_time", t < 500, 1);
  endtask

  initial begin
    int t, gap;
    #2;
    do_reset();

    // Single requester
    rq[0].push_back({1'b1, 8'hA5});
    en = 4'b0001;
    wait_sent(1);
    exp_q = '{8'hA5};
    check_sent();
    chk("single_back_to_idle", grant_valid_out, 0);

    // Contention, then a repeated full request
    do_reset();
    for (int r = 0; r < 2; r++) begin
      rq[0].push_back({1'b1, 8'h11});
      rq[1].push_back({1'b1, 8'h22});
      rq[2].push_back({1'b1, 8'h33});
      rq[3].push_back({1'b1, 8'h44});
      en = 4'b1111;
      wait_sent(4 * (r + 1));
    end
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
    check_sent();

    // Fairness between req1 and req3
    do_reset();
    exp_q.delete();
    for (int b = 0; b < 8; b++) begin
      rq[1].push_back({1'b1, 8'(8'h10 + b)});
      rq[3].push_back({1'b1, 8'(8'h30 + b)});
      exp_q.push_back(8'(8'h10 + b));
      exp_q.push_back(8'(8'h30 + b));
    end
    en = 4'b1010;
    wait_sent(16);
    check_sent();

    // Packet lock: req2 keeps the grant over req0
    do_reset();
    rq[2].push_back({1'b0, 8'h01});
    rq[2].push_back({1'b0, 8'h02});
    rq[2].push_back({1'b1, 8'h03});
    rq[0].push_back({1'b1, 8'hB0});
    en = 4'b0100;
    wait_ready(2);
    en = 4'b0101;
    wait_sent(4);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'hB0};
    check_sent();

    // Lock timeout
    do_reset();
    rq[1].push_back({1'b0, 8'h5A});
    rq[0].push_back({1'b1, 8'h0C});
    en = 4'b0010;
    wait_ready(1);
    en = 4'b0011;
    t = 0;
    while (tx_busy_in !== 1'b1 && t < 100) begin @(negedge sysclk_in); t++; end
    t = 0;
    while (tx_busy_in && t < 100) begin @(negedge sysclk_in); t++; end
    gap = 1;
    while (!req_ready_out[0] && gap < 200) begin
      if (gap == 10) begin
        chk("lock_hold_valid", grant_valid_out, 1'b1);
        chk("lock_hold_idx", grant_idx_out, 1);
      end
      @(negedge sysclk_in);
      gap++;
    end
    chk("timeout_gap", gap, 19);
    wait_sent(2);
    exp_q = '{8'h5A, 8'h0C};
    check_sent();

    // Reset mid-frame
    rq[0].push_back({1'b1, 8'h77});
    en = 4'b0001;
    t = 0;
    while (tx_busy_in !== 1'b1 && t < 100) begin @(negedge sysclk_in); t++; end
    @(posedge sysclk_in);
    #2;
    do_reset();
    rq[0].push_back({1'b1, 8'hC0});
    rq[2].push_back({1'b1, 8'hC2});
    en = 4'b0101;
    wait_sent(2);
    exp_q = '{8'hC0, 8'hC2};
    check_sent();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` instance between `N_REQ` byte producers. It accepts one byte at a time from a requester over a valid/ready handshake and presents the byte to the transmitter. It sequences `uart_tx` through `data_rdy_in`/`tx_busy_out`. An optional packet lock keeps the grant on one requester until that requester marks its last byte.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_BITS`, default 8: byte width; must match `uart_tx`.
- `LOCK_TIMEOUT`, default 1024: sysclk cycles an owner may idle in a locked packet before the lock is released; 0 means no timeout.

Ports (one clock; reset is asynchronous and active-high):
- `sysclk_in` in 1: system clock, the same clock as `uart_tx`.
- `rst_in` in 1: asynchronous active-high reset.
- `req_valid_in` in N_REQ: requester i has a byte.
- `req_data_in` in N_REQ*DATA_BITS: byte i occupies bits [i*DATA_BITS +: DATA_BITS].
- `req_last_in` in N_REQ: byte i is the last byte of its packet.
- `req_ready_out` out N_REQ: one-cycle pulse indicating byte i was accepted.
- `tx_data_out` out DATA_BITS: connects to `uart_tx.tx_data_in`.
- `data_rdy_out` out 1: connects to `uart_tx.data_rdy_in`.
- `tx_busy_in` in 1: from `uart_tx.tx_busy_out`.
- `grant_valid_out` out 1: a requester currently owns the transmitter.
- `grant_idx_out` out $clog2(N_REQ): index of the current owner.

## Operation
- States:
  - IDLE: no owner.
  - LOAD: `data_rdy_out` is high; waiting for `tx_busy_in` to rise.
  - SEND: waiting for `tx_busy_in` to fall.
  - HOLD: the packet is locked; waiting for the next byte from the owner.
- IDLE behaviour:
  - If any `req_valid_in` is high, select the first valid index starting at `(last_grant+1) mod N_REQ` and searching upward with wrap.
  - Register its data to `tx_data_out` and its last bit to `last_q`.
  - Set `grant_idx_out`/`last_grant` to the selected index and `grant_valid_out`=1.
  - Pulse `req_ready_out[idx]`, then go to LOAD.
- LOAD: when `tx_busy_in`=1, clear `data_rdy_out` and go to SEND.
- SEND: when `tx_busy_in`=0, go to IDLE if `last_q`=1, otherwise go to HOLD and clear the timeout counter.
- HOLD:
  - Only the owner is considered; the valid inputs of other requesters are ignored.
  - If the owner's valid is high, latch its byte and last bit, pulse its ready, and go to LOAD.
  - Otherwise increment the counter. If `LOCK_TIMEOUT`≠0 and the counter reaches `LOCK_TIMEOUT`, go to IDLE.
- `grant_valid_out` is 0 only in IDLE.
- Requester contract: hold valid, data, and last stable until ready is sampled high, then advance or drop on that same edge.
- `tx_data_out` is stable from entry into LOAD until the next byte is latched, so `uart_tx` may sample it at any point during its frame.
- Simultaneous requests: exactly one index receives ready; the others keep waiting, with no loss or duplication.
- `N_REQ` wrap: after index N_REQ-1, the search resumes at 0.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `req_ready_out`=0, `data_rdy_out`=0, `tx_data_out`=0, `grant_valid_out`=0, `grant_idx_out`=0, `last_grant`=N_REQ-1 (so index 0 wins first), counter=0.
- Latency: with valid sampled at edge k, `req_ready_out`, `data_rdy_out` and the new `tx_data_out` are all high/valid after edge k and stay valid through edge k+1.
  - `req_ready_out` is high for exactly one cycle.
  - `data_rdy_out` stays high until the edge after `tx_busy_in` is sampled high.
- Back-to-back: the next byte is latched on the first edge that sees `tx_busy_in`=0 in SEND+1. This gives no idle cycle beyond one arbitration edge.
- Reset mid-frame: all outputs clear immediately and any pending byte is dropped. `uart_tx` must be reset from the same source.
- A `tx_busy_in` rise seen in IDLE or HOLD is ignored.

## Test plan
1. Single requester: after reset, req0 sends 0xA5 with last=1 → one ready pulse, `data_rdy_out` high until busy rises, serial line carries 0xA5, and the arbiter returns to IDLE.
2. Contention: all 4 requesters are valid with last=1, carrying 0x11/0x22/0x33/0x44 → transmit order is 0x11, 0x22, 0x33, 0x44. A repeated full request then restarts at req0.
3. Round-robin fairness: req1 and req3 are continuously valid with 8 bytes each → transmissions alternate 1,3,1,3…, and no byte is lost or duplicated.
4. Packet lock: req2 sends 0x01, 0x02, 0x03 with last only on 0x03 while req0 is valid throughout → the serial order is 01, 02, 03 and then req0's byte.
5. Lock timeout with `LOCK_TIMEOUT`=16: req1 sends a byte with last=0 and then drops valid → after 16 cycles in HOLD the arbiter goes to IDLE, and the waiting req0 is granted.
6. Reset mid-frame: assert `rst_in` during SEND → all outputs read 0 within that cycle. After release, req0 wins first.
